// File: rtl/temporizador_if.sv
// Board-side signals of the countdown timer: preset switches in, LEDs and 7-segment digits out.
interface temporizador_if;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [7:0] LEDG;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [1:0] state_dbg;

    // Level signals only, no valid/ready: SW is sampled every cycle, outputs are registered levels.
    modport slave (
        input  SW,
        output LEDR, LEDG, HEX0, HEX1, HEX2, HEX3, state_dbg
    );

    modport master (
        output SW,
        input  LEDR, LEDG, HEX0, HEX1, HEX2, HEX3, state_dbg
    );
endinterface

// File: rtl/temporizador.sv
// Countdown timer SS.CC: loads 0..59 s from SW[5:0], counts centiseconds down to 00.00, then blinks LEDG.
module temporizador #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 100,
    parameter int BLINK_TICKS = 25
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    temporizador_if.slave io
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3} state_t;

    logic clk;
    logic rst_n;
    assign clk   = CLOCK_50;
    assign rst_n = KEY[1];

    logic unused_ok;
    assign unused_ok = &{1'b0, KEY[3], io.SW[9:6]};

    // [0],[1] synchronizer stages, [2] previous synchronized level for edge detection
    logic [2:0] start_sh_q, start_sh_d;
    logic [2:0] load_sh_q, load_sh_d;
    logic       start_p, load_p;

    state_t         state_q, state_d;
    logic [5:0]     sec_q, sec_d;
    logic [6:0]     cs_q, cs_d;
    logic [DW-1:0]  div_q, div_d;
    logic [BW-1:0]  blink_q, blink_d;
    logic           ledg_q, ledg_d;
    logic [9:0]     ledr_q, ledr_d;
    logic [3:0]     du_q, du_d, dd_q, dd_d, su_q, su_d, sd_q, sd_d;
    logic           tick;
    logic [5:0]     preset;

    always_comb begin
        start_sh_d = {start_sh_q[1:0], KEY[0]};
        load_sh_d  = {load_sh_q[1:0], KEY[2]};
        start_p    = start_sh_q[2] & ~start_sh_q[1];
        load_p     = load_sh_q[2] & ~load_sh_q[1];
    end

    assign tick   = (div_q == DW'(DIV - 1));
    assign preset = (io.SW[5:0] > 6'd59) ? 6'd59 : io.SW[5:0];

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        cs_d    = cs_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        blink_d = blink_q;
        ledg_d  = ledg_q;
        case (state_q)
            S_IDLE: begin
                if (load_p) begin
                    sec_d = preset;
                    cs_d  = '0;
                    div_d = '0;
                end else if (start_p && (sec_q != '0 || cs_q != '0)) begin
                    state_d = S_RUN;
                    div_d   = '0;
                end
            end
            S_RUN: begin
                // A start press freezes the count even if a tick lands on the same cycle.
                if (start_p) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    if (cs_q != '0) begin
                        cs_d = cs_q - 1'b1;
                    end else if (sec_q != '0) begin
                        cs_d  = 7'd99;
                        sec_d = sec_q - 1'b1;
                    end
                    if (sec_q == '0 && cs_q <= 7'd1) begin
                        state_d = S_DONE;
                        blink_d = '0;
                        ledg_d  = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (load_p) begin
                    state_d = S_IDLE;
                    sec_d   = preset;
                    cs_d    = '0;
                    div_d   = '0;
                end else if (start_p) begin
                    state_d = S_RUN;
                    div_d   = '0;
                end
            end
            S_DONE: begin
                if (load_p) begin
                    state_d = S_IDLE;
                    sec_d   = preset;
                    cs_d    = '0;
                    div_d   = '0;
                    ledg_d  = 1'b0;
                end else if (tick) begin
                    if (blink_q == BW'(BLINK_TICKS - 1)) begin
                        blink_d = '0;
                        ledg_d  = ~ledg_q;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // LEDR follows the next state so it is valid in the same cycle as the state register.
    always_comb begin
        ledr_d = 10'd0;
        case (state_d)
            S_RUN:   ledr_d = 10'h001;
            S_PAUSE: ledr_d = 10'h002;
            S_DONE:  ledr_d = 10'h004;
            default: ledr_d = 10'h008;
        endcase
    end

    always_comb begin
        du_d = 4'(cs_q % 7'd10);
        dd_d = 4'(cs_q / 7'd10);
        su_d = 4'(sec_q % 6'd10);
        sd_d = 4'(sec_q / 6'd10);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sh_q <= 3'b111;
            load_sh_q  <= 3'b111;
            state_q    <= S_IDLE;
            sec_q      <= '0;
            cs_q       <= '0;
            div_q      <= '0;
            blink_q    <= '0;
            ledg_q     <= 1'b0;
            ledr_q     <= 10'h008;
            du_q       <= '0;
            dd_q       <= '0;
            su_q       <= '0;
            sd_q       <= '0;
        end else begin
            start_sh_q <= start_sh_d;
            load_sh_q  <= load_sh_d;
            state_q    <= state_d;
            sec_q      <= sec_d;
            cs_q       <= cs_d;
            div_q      <= div_d;
            blink_q    <= blink_d;
            ledg_q     <= ledg_d;
            ledr_q     <= ledr_d;
            du_q       <= du_d;
            dd_q       <= dd_d;
            su_q       <= su_d;
            sd_q       <= sd_d;
        end
    end

    assign io.LEDR      = ledr_q;
    assign io.LEDG      = {8{ledg_q}};
    assign io.state_dbg = state_q;

    Display u_hex0 (.digit(du_q), .seg(io.HEX0));
    Display u_hex1 (.digit(dd_q), .seg(io.HEX1));
    Display u_hex2 (.digit(su_q), .seg(io.HEX2));
    Display u_hex3 (.digit(sd_q), .seg(io.HEX3));
endmodule

// Shared BCD to 7-segment decoder, segments active-low in gfedcba order; non-decimal codes blank.
module Display (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b1111111;
        case (digit)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// File: doc/temporizador.md
# temporizador

Countdown timer for the DE-series board: loads a preset in whole seconds (0–59) from switches and counts down in centiseconds to 00.00. On reaching zero it stops and blinks the green LEDs. It is the count-down counterpart of the stopwatch. It reuses the shared 7-segment `Display` decoder to drive HEX3..HEX0, which show SS.CC.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency.
- `TICK_HZ`, default 100: count rate (centiseconds). The divider terminal count is DIV = CLK_HZ/TICK_HZ.
- `BLINK_TICKS`, default 25: ticks per LEDG toggle in DONE (2 Hz blink).
- `CLOCK_50` input 1: single system clock. All logic is on its rising edge.
- `KEY[1]` input 1: reset, asynchronous, active-low.
- `KEY[0]` input 1: start/pause button, active-low.
- `KEY[2]` input 1: load button, active-low.
- `KEY[3]` input 1: unused.
- `SW` input 10: `SW[5:0]` holds the preset seconds; any value above 59 is clamped to 59. `SW[9:6]` are unused.
- `LEDR` output 10: `[0]`=RUN, `[1]`=PAUSE, `[2]`=DONE, `[3]`=IDLE; all other bits are 0.
- `LEDG` output 8: alarm blink, all bits equal.
- `HEX0`..`HEX3` output 7 each: centiseconds units, centiseconds tens, seconds units, seconds tens. Segments are active-low, produced by `Display`.

## Operation
- **Button inputs.** `KEY[0]` and `KEY[2]` each pass through a 2-FF synchronizer to `CLOCK_50`. A press is the synchronized 1→0 transition and produces a 1-cycle pulse. No other edge is used; the buttons never act as clocks.
- **Tick generator.** `div_cnt` counts 0..DIV-1. `tick` is a 1-cycle pulse when `div_cnt`=DIV-1. `div_cnt` is cleared on reset, on an accepted load, and on every entry into RUN.
- **Count registers.** `sec` is 6 bits (0–59) and `cs` is 7 bits (0–99), both binary.
- **State IDLE.** The preset is loaded; the display shows it.
  - Start with `sec`=`cs`=0: ignored, stay in IDLE.
  - Start otherwise: go to RUN.
- **State RUN.** On each `tick`:
  - If `cs`>0: `cs`--.
  - Else if `sec`>0: `cs`←99 and `sec`--.
  - If the result is 00.00, go to DONE on the same edge.
  - Start press: go to PAUSE, with counts frozen.
  - Load press: ignored.
- **State PAUSE.**
  - Start press: go to RUN; the next tick arrives a full DIV cycles later.
  - Load press: go to IDLE with the new preset.
- **State DONE.**
  - Counts hold at 00.00.
  - `blink_cnt` counts ticks; LEDG toggles every BLINK_TICKS ticks. LEDG is all-on on DONE entry.
  - Load press: go to IDLE with LEDG off.
  - Start press: ignored.
- **Load.** Sets `sec`←min(`SW[5:0]`,59) and `cs`←0.
- **Simultaneous presses.** If start and load pulse in the same cycle, load wins wherever load is accepted. In RUN, load is ignored, so start acts alone.
- **Display path.** `du`=`cs`%10, `dd`=`cs`/10, `su`=`sec`%10, `sd`=`sec`/10. These are registered, then decoded by `Display`.
- **Reset (`KEY[1]`=0)**, at any time including mid-RUN:
  - state becomes IDLE; `sec`, `cs`, `div_cnt` and `blink_cnt` become 0;
  - the synchronizers are set to 1 (released);
  - LEDG becomes 0 and LEDR becomes 10'b0000001000;
  - digits become 0, so every HEX shows 7'b1000000.
- **After reset release.** No press is detected until a genuine 1→0 on a key.

## Timing
- **Button latency.** Key falling edge → press pulse takes 3 clock edges (2 sync stages plus the edge register). State changes on the edge where the pulse is high.
- **Tick period.** Exactly DIV cycles in RUN; the first tick comes DIV cycles after entering RUN.
- **Count to display.** The digit registers update 1 cycle after `sec`/`cs`; HEX is combinational from the digit registers.
- **LEDR.** Registered from state; valid in the same cycle as the state.
- **Countdown duration.** Preset S≥1 reaches DONE after S×100 ticks = S×100×DIV cycles after entering RUN, excluding any paused time.

## Test plan
Directed scenarios use DIV=4 for simulation (`CLK_HZ`=400, `TICK_HZ`=100).
- **Reset.** Hold `KEY[1]`=0 mid-RUN → all HEX=7'b1000000, LEDR=10'h008, LEDG=0. After release with no presses, these values are stable.
- **Load and run.** `SW`=5, press load, press start → after 500 ticks (2000 cycles) state is DONE, display reads 00.00, LEDR[2]=1. One tick earlier the display reads 00.01.
- **Borrow.** Preset 2; after 1 tick the display reads 01.99. After 100 ticks it reads 01.00; after 101 ticks it reads 00.99.
- **Clamp and zero.** `SW`=63 plus load → 59.00 shown. `SW`=0 plus load, then start → stays in IDLE, LEDR[3]=1.
- **Pause and resume.** Pause at 03.47 for 50 cycles → display unchanged. Resume → the next decrement (to 03.46) comes exactly 4 cycles after RUN is entered. A load press during RUN changes nothing.
- **Alarm and simultaneous presses.**
  - In DONE, LEDG toggles every 25 ticks (100 cycles).
  - Start and load pressed in the same cycle while in DONE → state is IDLE with the new preset, LEDG=0.
